// File: rtl/tag_ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tag_ram_pkg                                                     |
// | Brief    : Shared types and helpers for the N-way tag store: flush FSM     |
// |            state, geometry derivation and tag parity.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package tag_ram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  // Way-select width; a single-way store still needs a 1-bit field.
  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int calc_sets(input int awidth);
    return 1 << awidth;
  endfunction

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic tag_parity(input logic [63:0] tag);
    return ^tag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_ram_way.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tag_ram_way                                                     |
// | Brief    : One way of the tag store: per-set tag, valid bit and tag        |
// |            comparator for the set currently being looked up.               |
// |            Optional macro TAG_RAM_PARITY_EN adds a stored parity bit.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tag_ram_way
  import tag_ram_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fill_en,
  input  logic              inv_en,
  input  logic              clr_en,
  input  logic [AWIDTH-1:0] wr_index,
  input  logic [TWIDTH-1:0] wr_tag,
  input  logic [AWIDTH-1:0] clr_index,
  input  logic [AWIDTH-1:0] rd_index,
  input  logic [TWIDTH-1:0] rd_tag,
  output logic              valid,
  output logic              hit,
  output logic              parity_bad
);

  localparam int SETS = calc_sets(AWIDTH);

  logic [SETS-1:0]   r_valid;
  logic [TWIDTH-1:0] r_tags [SETS];
  logic              w_par_ok;

  // Valid bits: flush clear, invalidate and fill never overlap (top qualifies them)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (inv_en) begin
        r_valid[wr_index] <= 1'b0;
      end else if (fill_en) begin
        r_valid[wr_index] <= 1'b1;
      end
      if (clr_en) begin
        r_valid[clr_index] <= 1'b0;
      end
    end
  end

  // Tag storage is deliberately unreset; the valid bit gates every use
  always_ff @(posedge clock) begin
    if (fill_en) begin
      r_tags[wr_index] <= wr_tag;
    end
  end

`ifdef TAG_RAM_PARITY_EN
  logic [SETS-1:0] r_par;

  // Parity is captured alongside the tag on every fill
  always_ff @(posedge clock) begin
    if (fill_en) begin
      r_par[wr_index] <= tag_parity(64'(wr_tag));
    end
  end

  assign w_par_ok   = (r_par[rd_index] == tag_parity(64'(r_tags[rd_index])));
  assign parity_bad = r_valid[rd_index] & ~w_par_ok;
`else
  assign w_par_ok   = 1'b1;
  assign parity_bad = 1'b0;
`endif

  assign valid = r_valid[rd_index];
  assign hit   = r_valid[rd_index] & w_par_ok & (r_tags[rd_index] == rd_tag);

endmodule
`default_nettype wire

// File: rtl/tag_ram_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tag_ram_nway                                                    |
// | Brief    : N-way set-associative tag store with synchronous lookup,        |
// |            hit/way detect, round-robin victim select, fill/invalidate     |
// |            writes and a one-set-per-cycle whole-array flush.               |
// |            Optional macro TAG_RAM_PARITY_EN enables tag parity checking.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tag_ram_nway
  import tag_ram_pkg::*;
#(
  parameter  int AWIDTH = 3,
  parameter  int TWIDTH = 14,
  parameter  int WAYS   = 4,
  localparam int WAY_W  = calc_way_w(WAYS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_index,
  input  logic [TWIDTH-1:0] req_tag,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [WAY_W-1:0]  rsp_way,
  output logic [WAY_W-1:0]  rsp_victim,
  input  logic              wr_en,
  input  logic              inv_en,
  input  logic [AWIDTH-1:0] wr_index,
  input  logic [WAY_W-1:0]  wr_way,
  input  logic [TWIDTH-1:0] wr_tag,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              parity_err
);

  localparam int SETS = calc_sets(AWIDTH);

  flush_state_t      r_state;
  logic [AWIDTH-1:0] r_fcnt;
  logic              r_busy;
  logic              r_ready;
  logic              r_rsp_valid;
  logic [AWIDTH-1:0] r_idx;
  logic [TWIDTH-1:0] r_tag;
  logic [WAY_W-1:0]  r_rr [SETS];

  logic              w_wr_ok;
  logic              w_fill;
  logic              w_inv;
  logic              w_clr;
  logic [WAYS-1:0]   w_valid;
  logic [WAYS-1:0]   w_hit;
  logic [WAYS-1:0]   w_bad;
  logic [WAY_W-1:0]  w_hit_way;
  logic [WAY_W-1:0]  w_victim;

  // Writes are dropped during flush; invalidate beats fill when both are asserted
  assign w_wr_ok = (r_state == IDLE);
  assign w_inv   = inv_en & w_wr_ok;
  assign w_fill  = wr_en & ~inv_en & w_wr_ok;
  assign w_clr   = (r_state == FLUSH);

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      tag_ram_way #(
        .AWIDTH (AWIDTH),
        .TWIDTH (TWIDTH)
      ) u_way (
        .clock      (clock),
        .reset      (reset),
        .fill_en    (w_fill && (wr_way == WAY_W'(w))),
        .inv_en     (w_inv && (wr_way == WAY_W'(w))),
        .clr_en     (w_clr),
        .wr_index   (wr_index),
        .wr_tag     (wr_tag),
        .clr_index  (r_fcnt),
        .rd_index   (r_idx),
        .rd_tag     (r_tag),
        .valid      (w_valid[w]),
        .hit        (w_hit[w]),
        .parity_bad (w_bad[w])
      );
    end
  endgenerate

  // Flush sequencer: walks r_fcnt over every set, one per cycle, holding off requests
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_fcnt  <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush_req) begin
            r_state <= FLUSH;
            r_fcnt  <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        FLUSH: begin
          if (r_fcnt == AWIDTH'(SETS - 1)) begin
            r_state <= IDLE;
            r_fcnt  <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_fcnt <= r_fcnt + AWIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lookup capture: index/tag held so the response reflects post-write array state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_idx       <= '0;
      r_tag       <= '0;
    end else begin
      r_rsp_valid <= req_valid & r_ready;
      if (req_valid & r_ready) begin
        r_idx <= req_index;
        r_tag <= req_tag;
      end
    end
  end

  // Per-set round-robin pointer: advances on each fill, cleared by flush
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
      end
    end else if (w_clr) begin
      r_rr[r_fcnt] <= '0;
    end else if (w_fill) begin
      r_rr[wr_index] <= r_rr[wr_index] + WAY_W'(1);
    end
  end

  // Priority encode: lowest-numbered matching way wins
  always_comb begin
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit[w]) begin
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    w_victim = r_rr[r_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_valid[w]) begin
        w_victim = WAY_W'(w);
      end
    end
  end

  assign req_ready  = r_ready;
  assign flush_busy = r_busy;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_hit    = r_rsp_valid & (|w_hit);
  assign rsp_way    = r_rsp_valid ? w_hit_way : '0;
  assign rsp_victim = r_rsp_valid ? w_victim  : '0;
  assign parity_err = r_rsp_valid & (|w_bad);

endmodule
`default_nettype wire
